dm_wt_cache: RTL and testbench
==============================

Name: dm_wt_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data/instruction cache between the multi-cycle CPU memory port and the backing word memory.
- Turns the CPU's single-port access into a req/ready handshake. Serves read hits locally and forwards misses and all writes to memory over a req/ack handshake.
- One line holds one 32-bit word.

Parameters:
- ADDR_W, 32, CPU/memory address width (byte address).
- DATA_W, 32, data word width.
- INDEX_BITS, 6, log2 of number of lines (64 lines).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU request; held high with addr/we/wdata stable until cpu_ready.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  input  DATA_W  write data.
- cpu_rdata  output  DATA_W  read data, valid while cpu_ready=1.
- cpu_ready  output  1  one-cycle completion pulse.
- mem_req  output  1  memory request, held until mem_ack.
- mem_write  output  1  1 = memory write for the current mem_req.
- mem_addr  output  ADDR_W  latched request address.
- mem_write_data  output  DATA_W  latched write data.
- mem_read_data  input  DATA_W  memory read data, valid with mem_ack.
- mem_ack  input  1  one-cycle memory completion.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all valid bits=0.
  - cpu_ready=0, mem_req=0, mem_write=0, cpu_rdata=0, mem_addr=0, mem_write_data=0.
  - A mem_ack arriving while in IDLE is ignored.
- Address split:
  - index = addr[INDEX_BITS+1:2].
  - tag = addr[ADDR_W-1:INDEX_BITS+2].
  - hit = valid[index] && tag_array[index]==tag.
- IDLE:
  - On a clock edge with cpu_req=1, latch addr/we/wdata into request registers and go to LOOKUP.
  - cpu_req=0 stays in IDLE.
- LOOKUP (combinational hit check on latched request):
  - Read hit: cpu_ready=1, cpu_rdata=data_array[index], next IDLE. Latency is 1 cycle after the request edge.
  - Read miss: next MEM_RD.
  - Write (hit or miss): next MEM_WR. On hit, data_array[index] is updated at this edge. On miss, the line is untouched (no allocate).
- MEM_RD:
  - Outputs: mem_req=1, mem_write=0, mem_addr=latched addr.
  - On mem_ack: valid[index]=1, tag/data written, cpu_rdata<=mem_read_data, next RESP.
- MEM_WR:
  - Outputs: mem_req=1, mem_write=1, mem_write_data=latched wdata.
  - On mem_ack: next RESP.
- RESP: cpu_ready=1 for exactly one cycle, next IDLE.
- Outputs and memory-side signals:
  - cpu_ready is never high in two consecutive cycles.
  - mem_req deasserts in the cycle after mem_ack.
  - mem_addr and mem_write_data are stable for the whole of mem_req.
- Back-to-back requests: a request already high in the IDLE cycle after cpu_ready is accepted at that edge. There is a minimum of 1 idle cycle between transactions.
- cpu_req dropping mid-transaction: ignored; the transaction completes.
- Reset mid-MEM_RD: no line fill; the pending ack is dropped.
- Memory latency: unbounded; no timeout.
- Index aliasing: a read miss evicts a valid line with the same index silently. No dirty state exists (write-through).

Optional Feature:
- Macro DM_WT_CACHE_STATS_EN.
- When defined, adds output ports hit_cnt[15:0] and miss_cnt[15:0]:
  - hit_cnt increments on a LOOKUP read hit.
  - miss_cnt increments on a LOOKUP read miss.
  - Both counters saturate at 16'hFFFF and reset to 0.
  - Writes are not counted.
- When undefined, neither the ports nor the logic exist; behaviour is otherwise identical.

Decomposition:
- Package dm_wt_cache_pkg:
  - State enum (IDLE, LOOKUP, MEM_RD, MEM_WR, RESP).
  - Default ADDR_W, DATA_W and INDEX_BITS constants.
  - Tag width function ADDR_W-INDEX_BITS-2.
- Sub-module dm_cache_array holds the valid/tag/data storage:
  - Async read by index.
  - Synchronous write of fill or update.
  - Async clear of valid bits on reset.
- The top level holds the FSM, request registers and handshake.

Test Plan:
- Cold read at addr 0x0000_0040, memory ack after 3 cycles with 0xDEAD_BEEF -> mem_req=1 with mem_addr=0x40, then RESP with cpu_rdata=0xDEAD_BEEF. A repeat read -> cpu_ready 1 cycle after req, no mem_req.
- Write 0x1234_5678 to cached 0x40 -> mem_write=1, mem_write_data=0x1234_5678. A following read hits and returns 0x1234_5678.
- Write to uncached 0x80 -> memory written. The following read of 0x80 misses (mem_req with mem_write=0), proving no allocate.
- Read 0x40 then 0x40+(4<<INDEX_BITS)=0x140 (same index) -> second read misses and evicts. A third read of 0x40 misses again.
- Assert reset=0 during MEM_RD before mem_ack, then ack arrives -> state IDLE, mem_req=0, cpu_ready stays 0. A later read of the same addr misses.
- With DM_WT_CACHE_STATS_EN: 3 read hits, 2 read misses, 1 write -> hit_cnt=3, miss_cnt=2. Forcing 70000 hits -> hit_cnt=16'hFFFF.

Source files
------------

// File: rtl/dm_wt_cache_pkg.sv
// Shared types and defaults for the direct-mapped write-through cache.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dm_wt_cache_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_INDEX_BITS = 6;

    // Controller states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Tag width: what remains of the byte address after index and byte offset
    function automatic int tag_w(input int addr_w, input int index_bits);
        return addr_w - index_bits - 2;
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache, one word per line.
// Latency: combinational read by index; fill/update written at the clock edge.
// Backpressure: none; the controller decides when to write.
//
// Ports:
//   clk, reset           clock, async active-low reset (clears valid bits only)
//   rd_index_i           line selected for the hit check
//   rd_valid_o/tag/data  contents of the selected line
//   fill_i               line fill: sets valid, writes tag and data
//   upd_i                write hit: overwrites data only (tag already matches)
//   wr_index_i/tag/data  write address and payload
module dm_cache_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W      = 24,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [DATA_W-1:0]     rd_data_o,
    input  logic                  fill_i,
    input  logic                  upd_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [DATA_W-1:0]     wr_data_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    // Only the valid bits need reset; stale tag/data behind a clear valid bit are harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
        if (fill_i || upd_i) begin
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/dm_wt_cache.sv
// Direct-mapped, write-through, no-write-allocate cache between CPU port and word memory.
// Latency: read hit ready 1 cycle after the accepting edge; misses/writes wait on mem_ack.
// Backpressure: cpu_req held until cpu_ready pulse; mem_req held until mem_ack (unbounded).
//
// Ports:
//   clk, reset          clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata  CPU request, held stable until cpu_ready
//   cpu_rdata/cpu_ready    read data and one-cycle completion pulse
//   mem_req/write/addr/write_data  memory request, held until mem_ack
//   mem_read_data/mem_ack  memory response
//   hit_cnt/miss_cnt    saturating read hit/miss counters, present only when
//                       DM_WT_CACHE_STATS_EN is defined
module dm_wt_cache
    import dm_wt_cache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ack
`ifdef DM_WT_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int TAG_W = tag_w(ADDR_W, INDEX_BITS);

    state_t            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              mem_req_q;
    logic              mem_write_q;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [DATA_W-1:0]     line_data;
    logic                  hit;
    logic                  lookup_rd_hit;
    logic                  lookup_rd_miss;
    logic                  fill;
    logic                  upd;

    // Hit check always runs on the latched request, never on live CPU inputs.
    assign index = addr_q[INDEX_BITS+1:2];
    assign tag   = addr_q[ADDR_W-1:INDEX_BITS+2];
    assign hit   = line_valid && (line_tag == tag);

    assign lookup_rd_hit  = (state_q == LOOKUP) && !we_q && hit;
    assign lookup_rd_miss = (state_q == LOOKUP) && !we_q && !hit;

    // Fill on read-miss return; write hits update the word in place, write misses leave the line alone.
    assign fill = (state_q == MEM_RD) && mem_ack;
    assign upd  = (state_q == LOOKUP) && we_q && hit;

    dm_cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .rd_index_i (index),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .fill_i     (fill),
        .upd_i      (upd),
        .wr_index_i (index),
        .wr_tag_i   (tag),
        .wr_data_i  (fill ? mem_read_data : wdata_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A stray mem_ack here is simply not looked at.
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (we_q) begin
                        mem_req_q   <= 1'b1;
                        mem_write_q <= 1'b1;
                        state_q     <= MEM_WR;
                    end else if (hit) begin
                        // Keep the hit data so cpu_rdata holds it after the pulse.
                        rdata_q <= line_data;
                        state_q <= IDLE;
                    end else begin
                        mem_req_q   <= 1'b1;
                        mem_write_q <= 1'b0;
                        state_q     <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        rdata_q   <= mem_read_data;
                        ready_q   <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                MEM_WR: begin
                    if (mem_ack) begin
                        mem_req_q   <= 1'b0;
                        mem_write_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read hits complete in LOOKUP itself; everything else completes in RESP from ready_q.
    // Both paths return to IDLE next, so the pulse can never repeat back to back.
    assign cpu_ready      = ready_q | lookup_rd_hit;
    assign cpu_rdata      = lookup_rd_hit ? line_data : rdata_q;
    assign mem_req        = mem_req_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;

`ifdef DM_WT_CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (lookup_rd_hit && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (lookup_rd_miss && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_wt_cache.sv
// Self-checking bench for dm_wt_cache: directed accesses, scoreboard queues, memory responder.
// Latency: n/a.
// Backpressure: memory responder acks after a per-access latency, or is held off manually.
module tb_dm_wt_cache;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ack;
`ifdef DM_WT_CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    dm_wt_cache dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .mem_req        (mem_req),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ack        (mem_ack)
`ifdef DM_WT_CACHE_STATS_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        int          lat;      // 0 = latency not checked
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mtx_t;

    rsp_t        exp_rsp [$];
    mtx_t        exp_mem [$];
    logic [31:0] mem_model [logic [31:0]];
    int          mem_lat;
    bit          hold;
    int          exp_hits;
    int          exp_misses;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // One CPU access: push expectations, drive request, wait (bounded) for completion.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic hit, input logic [31:0] rdata, input int lat);
        rsp_t r;
        mtx_t m;
        bit   done;
        r.chk_data = !we;
        r.data     = rdata;
        r.lat      = (!we && hit) ? 1 : 0;
        exp_rsp.push_back(r);
        if (we || !hit) begin
            m.wr    = we;
            m.addr  = addr;
            m.wdata = wdata;
            exp_mem.push_back(m);
        end
        if (!we) begin
            if (hit) begin
                if (exp_hits < 65535) exp_hits++;
            end else begin
                if (exp_misses < 65535) exp_misses++;
            end
        end
        mem_lat = lat;
        @(posedge clk);
        #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (cpu_ready) done = 1'b1;
        end
        if (!done) fail_now("cpu_ready_timeout");
        @(posedge clk);
        #1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_wdata = 32'h0;
    endtask

    // Memory responder: acks mem_lat cycles after mem_req rises, updates/reads the model.
    initial begin
        int wcnt;
        bit acked;
        mem_ack       = 1'b0;
        mem_read_data = 32'h0;
        wcnt  = 0;
        acked = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!hold) begin
                mem_ack = 1'b0;
                if (!mem_req) begin
                    acked = 1'b0;
                    wcnt  = 0;
                end else if (!acked) begin
                    wcnt++;
                    if (wcnt >= mem_lat) begin
                        mem_ack = 1'b1;
                        acked   = 1'b1;
                        if (mem_write) mem_model[mem_addr] = mem_write_data;
                        else           mem_read_data = mem_model[mem_addr];
                    end
                end
            end
        end
    end

    // CPU-side monitor: pops the response scoreboard on each cpu_ready.
    initial begin
        bit   in_txn;
        bit   prev_rdy;
        int   cnt;
        rsp_t r;
        in_txn   = 1'b0;
        prev_rdy = 1'b0;
        cnt      = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_txn   = 1'b0;
                prev_rdy = 1'b0;
            end else begin
                if (cpu_ready) begin
                    check("cpu_ready_back_to_back", 32'(prev_rdy), 32'h0);
                    if (exp_rsp.size() == 0) begin
                        fail_now("unexpected_cpu_ready");
                    end else begin
                        r = exp_rsp.pop_front();
                        if (r.chk_data) check("cpu_rdata", cpu_rdata, r.data);
                        if (r.lat != 0) check("hit_latency", 32'(cnt + 1), 32'(r.lat));
                    end
                    in_txn = 1'b0;
                end else if (in_txn) begin
                    cnt++;
                end else if (cpu_req) begin
                    in_txn = 1'b1;
                    cnt    = 0;
                end
                prev_rdy = cpu_ready;
            end
        end
    end

    // Memory-side monitor: pops the memory scoreboard when mem_req rises, checks stability.
    initial begin
        bit   prev_req;
        bit   prev_ack;
        mtx_t cur;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        cur.wr = 1'b0; cur.addr = 32'h0; cur.wdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (prev_ack) check("mem_req_after_ack", 32'(mem_req), 32'h0);
                if (mem_req && !prev_req) begin
                    if (exp_mem.size() == 0) begin
                        fail_now("unexpected_mem_req");
                    end else begin
                        cur = exp_mem.pop_front();
                        check("mem_write", 32'(mem_write), 32'(cur.wr));
                        check("mem_addr", mem_addr, cur.addr);
                        if (cur.wr) check("mem_write_data", mem_write_data, cur.wdata);
                    end
                end else if (mem_req) begin
                    check("mem_addr_stable", mem_addr, cur.addr);
                    if (cur.wr) check("mem_wdata_stable", mem_write_data, cur.wdata);
                end
                prev_req = mem_req;
                prev_ack = mem_ack;
            end
        end
    end

    initial begin
        mtx_t m;
        bit   seen;
        checks     = 0;
        errors     = 0;
        exp_hits   = 0;
        exp_misses = 0;
        mem_lat    = 3;
        hold       = 1'b0;
        reset      = 1'b0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = 32'h0;
        cpu_wdata  = 32'h0;
        mem_model[32'h0000_0040] = 32'hDEAD_BEEF;
        mem_model[32'h0000_0140] = 32'hCAFE_F00D;
        mem_model[32'h0000_0300] = 32'h0BAD_F00D;

        repeat (2) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_write_data", mem_write_data, 32'h0);
`ifdef DM_WT_CACHE_STATS_EN
        check("rst_hit_cnt", 32'(hit_cnt), 32'h0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'h0);
`endif
        reset = 1'b1;

        //     we    addr          wdata         hit   rdata         lat
        access(1'b0, 32'h0000_0040, 32'h0,        1'b0, 32'hDEAD_BEEF, 3); // cold miss
        access(1'b0, 32'h0000_0040, 32'h0,        1'b1, 32'hDEAD_BEEF, 3); // repeat hits
        access(1'b1, 32'h0000_0040, 32'h1234_5678, 1'b1, 32'h0,        2); // write hit, through
        access(1'b0, 32'h0000_0040, 32'h0,        1'b1, 32'h1234_5678, 3); // sees update
        access(1'b1, 32'h0000_0080, 32'hA5A5_5A5A, 1'b0, 32'h0,        1); // write miss
        access(1'b0, 32'h0000_0080, 32'h0,        1'b0, 32'hA5A5_5A5A, 5); // no allocate
        access(1'b0, 32'h0000_0080, 32'h0,        1'b1, 32'hA5A5_5A5A, 3); // now filled
        access(1'b0, 32'h0000_0140, 32'h0,        1'b0, 32'hCAFE_F00D, 4); // alias evicts 0x40
        access(1'b0, 32'h0000_0040, 32'h0,        1'b0, 32'h1234_5678, 1); // 0x40 misses again

        // Reset in the middle of MEM_RD; a late ack must not fill or complete anything.
        m.wr = 1'b0; m.addr = 32'h0000_0300; m.wdata = 32'h0;
        exp_mem.push_back(m);
        hold = 1'b1;
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_0300;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        if (!seen) fail_now("mem_req_timeout");
        reset      = 1'b0;
        cpu_req    = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge clk);
        check("rst_mid_mem_req", 32'(mem_req), 32'h0);
        check("rst_mid_cpu_ready", 32'(cpu_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        mem_ack       = 1'b1;
        mem_read_data = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stale_ack_cpu_ready", 32'(cpu_ready), 32'h0);
            check("stale_ack_mem_req", 32'(mem_req), 32'h0);
        end
        hold = 1'b0;

        access(1'b0, 32'h0000_0300, 32'h0, 1'b0, 32'h0BAD_F00D, 2); // no fill happened
        access(1'b0, 32'h0000_0300, 32'h0, 1'b1, 32'h0BAD_F00D, 3);

`ifdef DM_WT_CACHE_STATS_EN
        @(negedge clk);
        check("hit_cnt", 32'(hit_cnt), 32'(exp_hits));
        check("miss_cnt", 32'(miss_cnt), 32'(exp_misses));
        // Preload the hit counter near the top, then overrun it.
        @(posedge clk);
        #1;
        force dut.hit_cnt_q = 16'hFFFD;
        #1;
        release dut.hit_cnt_q;
        exp_hits = 65533;
        repeat (4) access(1'b0, 32'h0000_0300, 32'h0, 1'b1, 32'h0BAD_F00D, 3);
        @(negedge clk);
        check("hit_cnt_saturated", 32'(hit_cnt), 32'(exp_hits));
        check("miss_cnt_after_sat", 32'(miss_cnt), 32'(exp_misses));
`endif

        repeat (3) @(negedge clk);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'h0);
        check("mem_queue_drained", 32'(exp_mem.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
